// File: rtl/pr_free_list_mw.sv
// Multi-width physical-register free list: circular buffer of free PR numbers with
// compacted alloc/free lanes, checkpoint flush of the head, live count and sticky overflow.
module pr_free_list_mw #(
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 16,
  parameter int WIDTH  = 4,
  parameter int DEPTH  = NUM_PR - NUM_AR,
  parameter int PR_W   = $clog2(NUM_PR),
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [WIDTH-1:0]      alloc_req,
  output logic [WIDTH*PR_W-1:0] alloc_pr,
  output logic                  alloc_ok,
  input  logic [WIDTH-1:0]      free_valid,
  input  logic [WIDTH*PR_W-1:0] free_pr,
  input  logic                  flush,
  input  logic [IDX_W:0]        flush_ptr,
  output logic [IDX_W:0]        curr_ptr,
  output logic [IDX_W:0]        free_count,
  output logic                  list_empty,
  output logic                  overflow_err
);

  typedef logic [IDX_W:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // Pointers are {wrap, idx}; idx wraps modulo DEPTH, which need not be a power of two.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t k);
    ptr_t sum;
    sum = {1'b0, p[IDX_W-1:0]} + k;
    if (sum >= DEPTH_P) return {~p[IDX_W], IDX_W'(sum - DEPTH_P)};
    return {p[IDX_W], sum[IDX_W-1:0]};
  endfunction

  logic [PR_W-1:0] entries_q [DEPTH];
  logic [PR_W-1:0] entries_d [DEPTH];
  ptr_t            head_q, head_d, tail_q, tail_d;
  logic            ovf_q, ovf_d;

  ptr_t            alloc_cnt, alloc_amt, free_cnt, rd_ptr, wr_ptr, wr_cnt;
  logic [IDX_W+1:0] post_cnt;
  logic            free_drop;

  always_comb begin
    if (head_q[IDX_W] == tail_q[IDX_W])
      free_count = {1'b0, tail_q[IDX_W-1:0]} - {1'b0, head_q[IDX_W-1:0]};
    else
      free_count = DEPTH_P - {1'b0, head_q[IDX_W-1:0]} + {1'b0, tail_q[IDX_W-1:0]};
  end

  // Handshake: alloc_req lanes are a sparse request judged all-or-nothing by alloc_ok;
  // the grant is consumed only when alloc_ok & !stall & !flush. free_valid lanes carry no
  // back-pressure: they are accepted unless the group would overflow, then dropped whole.
  always_comb begin
    alloc_cnt = '0;
    rd_ptr    = head_q;
    alloc_pr  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_ptr = ptr_add(head_q, alloc_cnt);
      if (alloc_req[i]) begin
        alloc_pr[i*PR_W +: PR_W] = entries_q[rd_ptr[IDX_W-1:0]];
        alloc_cnt = alloc_cnt + ptr_t'(1);
      end
    end
    alloc_ok  = (alloc_cnt <= free_count);
    alloc_amt = (alloc_ok && !stall && !flush) ? alloc_cnt : '0;
  end

  always_comb begin
    free_cnt  = ptr_t'($countones(free_valid));
    post_cnt  = {1'b0, free_count} - {1'b0, alloc_amt} + {1'b0, free_cnt};
    free_drop = (post_cnt > (IDX_W+2)'(DEPTH));
    entries_d = entries_q;
    wr_cnt    = '0;
    wr_ptr    = tail_q;
    for (int j = 0; j < WIDTH; j++) begin
      wr_ptr = ptr_add(tail_q, wr_cnt);
      if (free_valid[j]) begin
        if (!free_drop) entries_d[wr_ptr[IDX_W-1:0]] = free_pr[j*PR_W +: PR_W];
        wr_cnt = wr_cnt + ptr_t'(1);
      end
    end
    tail_d = free_drop ? tail_q : ptr_add(tail_q, free_cnt);
    head_d = flush ? flush_ptr : ptr_add(head_q, alloc_amt);
    ovf_d  = ovf_q | free_drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= {1'b1, {IDX_W{1'b0}}};
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= PR_W'(NUM_AR + i);
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      ovf_q     <= ovf_d;
      entries_q <= entries_d;
    end
  end

  assign curr_ptr     = head_q;
  assign list_empty   = (free_count == '0);
  assign overflow_err = ovf_q;

endmodule
